// File: rtl/risc_v_32_i_pkg.sv
// Shared types for the RV32I front end: sequencer states, trap causes and next-PC selects.
// Imported by the PC sequencer and its next-PC datapath.
package risc_v_32_i_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } pc_state_e;

    // Encodings are architecturally visible on trap_cause_o.
    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_MISALIGN = 2'd1,
        TRAP_FETCH_TO = 2'd2
    } trap_cause_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } next_pc_sel_e;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: priority select, target adders and word-alignment check.
// All additions wrap modulo 2^XLEN.
module next_pc_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            branch,
    input  logic            comp,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    import risc_v_32_i_pkg::*;

    next_pc_sel_e    sel;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] jalr_sum;

    assign seq_target = pc + XLEN'(PC_STEP);
    assign rel_target = pc + imm;
    assign jalr_sum   = rs1 + imm;

    // JALR outranks JAL, which outranks a taken branch; comp only matters for branches.
    always_comb begin
        sel = NPC_SEQ;
        if (jalr) begin
            sel = NPC_JALR;
        end else if (jal) begin
            sel = NPC_JAL;
        end else if (branch && comp) begin
            sel = NPC_BRANCH;
        end
    end

    always_comb begin
        target = seq_target;
        case (sel)
            NPC_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            NPC_JAL:    target = rel_target;
            NPC_BRANCH: target = rel_target;
            default:    target = seq_target;
        endcase
    end

    assign misaligned = is_misaligned(target[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: req/ack instruction fetch, next-PC resolution
// after the branch comparator, and trap capture for misaligned targets and fetch timeouts.
module pc_sequencer #(
    parameter int                 XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_VEC = 'h0000_0000,
    parameter logic [XLEN-1:0]    TRAP_VEC  = 'h0000_0100,
    parameter int unsigned        TIMEOUT   = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            comp_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            stall_i,
    input  logic            trap_clear_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            trap_o,
    output logic [1:0]      trap_cause_o,
    output logic [XLEN-1:0] trap_addr_o
);
    import risc_v_32_i_pkg::*;

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    pc_state_e          state;
    pc_state_e          state_next;
    logic [XLEN-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   fetch_cnt;
    trap_cause_e        trap_cause_q;
    logic [XLEN-1:0]    trap_addr_q;

    logic [XLEN-1:0]    target;
    logic               target_misaligned;
    logic               timeout_hit;

    next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .pc         (pc_q),
        .imm        (imm_i),
        .rs1        (rs1_i),
        .branch     (branch_i),
        .comp       (comp_i),
        .jal        (jal_i),
        .jalr       (jalr_i),
        .target     (target),
        .misaligned (target_misaligned)
    );

    assign timeout_hit = (fetch_cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // An ack arriving on the last permitted wait cycle still wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack_i) begin
                    state_next = S_EXEC;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC: begin
                if (!stall_i) begin
                    state_next = target_misaligned ? S_TRAP : S_FETCH;
                end
            end
            S_TRAP: begin
                if (trap_clear_i) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        trap_o        = 1'b0;
        case (state)
            S_FETCH: imem_req_o    = 1'b1;
            S_EXEC:  instr_valid_o = 1'b1;
            S_TRAP:  trap_o        = 1'b1;
            default: ;
        endcase
    end

    // A misaligned target leaves the PC on the offending instruction so the handler can see it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_VEC;
            instr_q      <= '0;
            fetch_cnt    <= '0;
            trap_cause_q <= TRAP_NONE;
            trap_addr_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        instr_q   <= imem_rdata_i;
                        fetch_cnt <= '0;
                    end else if (timeout_hit) begin
                        fetch_cnt    <= '0;
                        trap_cause_q <= TRAP_FETCH_TO;
                        trap_addr_q  <= pc_q;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall_i) begin
                        if (target_misaligned) begin
                            trap_cause_q <= TRAP_MISALIGN;
                            trap_addr_q  <= target;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                S_TRAP: begin
                    if (trap_clear_i) begin
                        pc_q         <= TRAP_VEC;
                        trap_cause_q <= TRAP_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign link_o       = pc_q + XLEN'(PC_STEP);
    assign instr_o      = instr_q;
    assign trap_cause_o = trap_cause_q;
    assign trap_addr_o  = trap_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a behavioural reference model.
module tb_pc_sequencer;

    localparam int          XLEN      = 32;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_TRAP  = 3;

    logic        clk;
    logic        rst;
    logic        comp, branch, jal, jalr, stall, trap_clear, imem_ack;
    logic [31:0] imm, rs1, imem_rdata;
    logic        imem_req, instr_valid, trap;
    logic [31:0] imem_addr, instr, pc, link, trap_addr;
    logic [1:0]  trap_cause;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        branch;
        logic        comp;
        logic        jal;
        logic        jalr;
        logic        clr;
        logic [31:0] imm;
        logic [31:0] rs1;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        req;
        logic        valid;
        logic        trap;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic [31:0] taddr;
    } vec_t;

    int n_compared;
    int n_mismatched;

    int          m_phase;
    int          m_waited;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [1:0]  m_cause;
    logic [31:0] m_taddr;

    vec_t tbl[$];

    pc_sequencer #(
        .XLEN      (XLEN),
        .RESET_VEC (RESET_VEC),
        .TRAP_VEC  (TRAP_VEC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .comp_i        (comp),
        .branch_i      (branch),
        .jal_i         (jal),
        .jalr_i        (jalr),
        .imm_i         (imm),
        .rs1_i         (rs1),
        .stall_i       (stall),
        .trap_clear_i  (trap_clear),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .link_o        (link),
        .trap_o        (trap),
        .trap_cause_o  (trap_cause),
        .trap_addr_o   (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic ack, input logic stl, input logic br, input logic cmp,
                                 input logic j, input logic jr, input logic clr,
                                 input logic [31:0] im, input logic [31:0] r1);
        stim_t s;
        s.ack = ack; s.rdata = 32'h0; s.stall = stl; s.branch = br; s.comp = cmp;
        s.jal = j; s.jalr = jr; s.clr = clr; s.imm = im; s.rs1 = r1;
        return s;
    endfunction

    task automatic add_vec(input stim_t s, input logic rq, input logic vl, input logic tr,
                           input logic [31:0] p, input logic [1:0] c, input logic [31:0] ta);
        vec_t v;
        v.in = s; v.req = rq; v.valid = vl; v.trap = tr; v.pc = p; v.cause = c; v.taddr = ta;
        tbl.push_back(v);
    endtask

    // Reference model: the documented sequencing rules expressed with plain integer arithmetic.
    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_waited = 0;
        m_pc     = RESET_VEC;
        m_instr  = 32'h0;
        m_cause  = 2'd0;
        m_taddr  = 32'h0;
    endtask

    task automatic model_step(input stim_t s);
        longint unsigned t;
        case (m_phase)
            PH_IDLE: m_phase = PH_FETCH;
            PH_FETCH: begin
                if (s.ack) begin
                    m_instr  = s.rdata;
                    m_waited = 0;
                    m_phase  = PH_EXEC;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_cause  = 2'd2;
                    m_taddr  = m_pc;
                    m_waited = 0;
                    m_phase  = PH_TRAP;
                end else begin
                    m_waited = m_waited + 1;
                end
            end
            PH_EXEC: begin
                if (!s.stall) begin
                    if (s.jalr) begin
                        t = (64'(s.rs1) + 64'(s.imm)) % 64'h1_0000_0000;
                        t = t - (t % 2);
                    end else if (s.jal || (s.branch && s.comp)) begin
                        t = (64'(m_pc) + 64'(s.imm)) % 64'h1_0000_0000;
                    end else begin
                        t = (64'(m_pc) + 64'd4) % 64'h1_0000_0000;
                    end
                    if (t % 4 != 0) begin
                        m_cause = 2'd1;
                        m_taddr = 32'(t);
                        m_phase = PH_TRAP;
                    end else begin
                        m_pc    = 32'(t);
                        m_phase = PH_FETCH;
                    end
                end
            end
            default: begin
                if (s.clr) begin
                    m_pc    = TRAP_VEC;
                    m_cause = 2'd0;
                    m_phase = PH_FETCH;
                end
            end
        endcase
    endtask

    task automatic check_model();
        check_val("model_req",   {31'b0, imem_req},    {31'b0, m_phase == PH_FETCH});
        check_val("model_valid", {31'b0, instr_valid}, {31'b0, m_phase == PH_EXEC});
        check_val("model_trap",  {31'b0, trap},        {31'b0, m_phase == PH_TRAP});
        check_val("model_pc",    pc,        m_pc);
        check_val("model_addr",  imem_addr, m_pc);
        check_val("model_link",  link,      m_pc + 32'd4);
        check_val("model_instr", instr,     m_instr);
        check_val("model_cause", {30'b0, trap_cause}, {30'b0, m_cause});
        check_val("model_taddr", trap_addr, m_taddr);
    endtask

    task automatic apply_stimulus(input stim_t s);
        imem_ack   = s.ack;
        imem_rdata = s.rdata;
        stall      = s.stall;
        branch     = s.branch;
        comp       = s.comp;
        jal        = s.jal;
        jalr       = s.jalr;
        trap_clear = s.clr;
        imm        = s.imm;
        rs1        = s.rs1;
        @(negedge clk);
        check_model();
    endtask

    task automatic end_cycle(input stim_t s);
        @(posedge clk);
        if (!rst) model_step(s);
        #1;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check_val({tag, "_req"},   {31'b0, imem_req},    {31'b0, v.req});
        check_val({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, v.valid});
        check_val({tag, "_trap"},  {31'b0, trap},        {31'b0, v.trap});
        check_val({tag, "_pc"},    pc,        v.pc);
        check_val({tag, "_addr"},  imem_addr, v.pc);
        check_val({tag, "_link"},  link,      v.pc + 32'd4);
        check_val({tag, "_cause"}, {30'b0, trap_cause}, {30'b0, v.cause});
        check_val({tag, "_taddr"}, trap_addr, v.taddr);
    endtask

    initial begin
        stim_t s;
        stim_t idle;
        int    r;

        n_compared   = 0;
        n_mismatched = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Directed table: inputs for each cycle with outputs expected during that cycle.
        add_vec(idle,                                          0, 0, 0, 32'h00, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h00, 2'd0, 32'h0);
        add_vec(idle,                                          0, 1, 0, 32'h00, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h04, 2'd0, 32'h0);
        add_vec(mk(0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h0),        0, 1, 0, 32'h04, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h08, 2'd0, 32'h0);
        add_vec(idle,                                          0, 1, 0, 32'h08, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h0C, 2'd0, 32'h0);
        add_vec(idle,                                          0, 1, 0, 32'h0C, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h10, 2'd0, 32'h0);
        add_vec(mk(0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0), 0, 1, 0, 32'h10, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h08, 2'd0, 32'h0);
        add_vec(idle,                                          0, 1, 0, 32'h08, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h0C, 2'd0, 32'h0);
        add_vec(idle,                                          0, 1, 0, 32'h0C, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h10, 2'd0, 32'h0);
        add_vec(mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0), 0, 1, 0, 32'h10, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h14, 2'd0, 32'h0);
        add_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h0C, 32'h0),        0, 1, 0, 32'h14, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h20, 2'd0, 32'h0);
        add_vec(mk(0, 0, 0, 0, 1, 1, 0, 32'h3, 32'h1001),      0, 1, 0, 32'h20, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h1004, 2'd0, 32'h0);
        add_vec(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h40),        0, 1, 0, 32'h1004, 2'd0, 32'h0);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h40, 2'd0, 32'h0);
        add_vec(mk(0, 0, 0, 0, 1, 0, 0, 32'h6, 32'h0),         0, 1, 0, 32'h40, 2'd0, 32'h0);
        add_vec(idle,                                          0, 0, 1, 32'h40, 2'd1, 32'h46);
        add_vec(mk(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0),         0, 0, 1, 32'h40, 2'd1, 32'h46);
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0),         1, 0, 0, 32'h100, 2'd0, 32'h46);
        add_vec(idle,                                          0, 1, 0, 32'h100, 2'd0, 32'h46);

        imem_ack = 0; imem_rdata = 0; stall = 0; branch = 0; comp = 0;
        jal = 0; jalr = 0; trap_clear = 0; imm = 0; rs1 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < tbl.size(); i++) begin
            s = tbl[i].in;
            s.rdata = 32'hA000_0000 | 32'(i);
            apply_stimulus(s);
            check_output(tbl[i], i);
            end_cycle(s);
        end

        $display("[TB] fetch timeout with ack withheld");
        for (int k = 0; k < TIMEOUT; k++) begin
            apply_stimulus(idle);
            check_val("to_wait_req", {31'b0, imem_req}, 32'd1);
            check_val("to_wait_trap", {31'b0, trap}, 32'd0);
            end_cycle(idle);
        end
        apply_stimulus(idle);
        check_val("to_trap", {31'b0, trap}, 32'd1);
        check_val("to_cause", {30'b0, trap_cause}, 32'd2);
        check_val("to_taddr", trap_addr, 32'h104);
        end_cycle(idle);
        s = mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        apply_stimulus(s);
        end_cycle(s);

        $display("[TB] ack on the last permitted fetch cycle");
        for (int k = 0; k < TIMEOUT; k++) begin
            s = mk(k == TIMEOUT - 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
            s.rdata = 32'hC0DE_0000 | 32'(k);
            apply_stimulus(s);
            check_val("late_ack_req", {31'b0, imem_req}, 32'd1);
            check_val("late_ack_pc", pc, 32'h100);
            end_cycle(s);
        end
        apply_stimulus(idle);
        check_val("late_ack_valid", {31'b0, instr_valid}, 32'd1);
        check_val("late_ack_trap", {31'b0, trap}, 32'd0);

        $display("[TB] stall in execute");
        s = mk(0, 1, 0, 0, 1, 0, 0, 32'h20, 32'h0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(s);
            check_val("stall_valid", {31'b0, instr_valid}, 32'd1);
            check_val("stall_req", {31'b0, imem_req}, 32'd0);
            check_val("stall_pc", pc, 32'h100);
            check_val("stall_instr", instr, 32'hC0DE_000F);
            end_cycle(s);
        end
        s.stall = 1'b0;
        apply_stimulus(s);
        end_cycle(s);
        apply_stimulus(idle);
        check_val("unstall_addr", imem_addr, 32'h120);

        $display("[TB] reset during an outstanding fetch");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_req", {31'b0, imem_req}, 32'd0);
        check_val("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_val("rst_trap", {31'b0, trap}, 32'd0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_cause", {30'b0, trap_cause}, 32'd0);
        check_val("rst_taddr", trap_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(idle);
        check_val("rst_idle_req", {31'b0, imem_req}, 32'd0);
        end_cycle(idle);
        s = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        s.rdata = 32'h1234_5678;
        apply_stimulus(s);
        check_val("rst_refetch_addr", imem_addr, 32'h0);
        end_cycle(s);

        $display("[TB] randomized traffic against reference model");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc / 300) % 3 == 2) begin
                s.ack = ($urandom_range(0, 24) == 0);
            end else begin
                s.ack = $urandom_range(0, 1) == 1;
            end
            s.rdata  = $urandom;
            s.stall  = ($urandom_range(0, 3) == 0);
            s.branch = ($urandom_range(0, 3) == 0);
            s.comp   = $urandom_range(0, 1) == 1;
            s.jal    = ($urandom_range(0, 3) == 0);
            s.jalr   = ($urandom_range(0, 3) == 0);
            s.clr    = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                s.imm = 32'((int'($urandom_range(0, 64)) - 32) * 4);
            end else if (r < 7) begin
                s.imm = $urandom;
            end else begin
                s.imm = 32'((int'($urandom_range(0, 64)) - 32) * 4 + int'($urandom_range(1, 3)));
            end
            s.rs1 = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            apply_stimulus(s);
            end_cycle(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer directly downstream of the branch comparator.
- Consumes the comparator's 1-bit decision plus decode control and operands, and resolves the next PC (sequential, branch, JAL, JALR).
- Drives a req/ack instruction-memory handshake and presents each fetched instruction to decode for exactly one accepted cycle.
- Raises traps on misaligned targets and on fetch timeout.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_VEC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap clear.
- TIMEOUT, 16, maximum cycles waiting for imem_ack_i before a bus-error trap (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- comp_i  in  1  branch-taken decision from the comparator (valid in S_EXEC).
- branch_i  in  1  current instruction is a conditional branch.
- jal_i  in  1  current instruction is JAL.
- jalr_i  in  1  current instruction is JALR.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_i  in  XLEN  rs1 value for JALR.
- stall_i  in  1  hold the current instruction; no PC update.
- trap_clear_i  in  1  acknowledge trap and restart at TRAP_VEC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address (= pc_o).
- imem_ack_i  in  1  fetch data valid.
- imem_rdata_i  in  32  fetched instruction.
- instr_o  out  32  registered instruction.
- instr_valid_o  out  1  instr_o valid (S_EXEC).
- pc_o  out  XLEN  current PC.
- link_o  out  XLEN  pc_o+4, for rd on JAL/JALR.
- trap_o  out  1  trap pending.
- trap_cause_o  out  2  trap cause: 0 none, 1 misaligned target, 2 fetch timeout.
- trap_addr_o  out  XLEN  offending target or fetch address.

Behaviour:
- Reset: the asynchronous assertion of rst_i sets:
  - state to S_RESET;
  - pc to RESET_VEC;
  - instr_o, trap_cause_o and trap_addr_o to 0;
  - imem_req_o, instr_valid_o and trap_o to 0;
  - the timeout counter to 0.
- Reset mid-fetch: any outstanding ack is ignored and the sequencer restarts cleanly.
- S_RESET: one cycle with all outputs idle, then S_FETCH unconditionally.
- S_FETCH:
  - imem_req_o=1 and imem_addr_o=pc.
  - On imem_ack_i: instr_o<=imem_rdata_i, counter cleared, go to S_EXEC. An ack in the first S_FETCH cycle is legal, giving a minimum 1-cycle fetch latency.
  - Without ack: counter increments. When the counter reaches TIMEOUT-1 and there is still no ack: trap_cause 2, trap_addr=pc, go to S_TRAP.
  - An ack in that same cycle wins over the timeout.
- S_EXEC:
  - instr_valid_o=1.
  - If stall_i: hold state, pc and instr_o.
  - Otherwise compute the target, with priority jalr_i > jal_i > branch_i&comp_i > sequential:
    - JALR: (rs1_i+imm_i) with bit0 cleared.
    - JAL or taken branch: pc+imm_i.
    - Sequential: pc+4.
  - All additions are modulo 2^XLEN; wrap-around is silent.
  - If target[1:0]!=0: trap_cause 1, trap_addr=target, pc unchanged, go to S_TRAP.
  - Else pc<=target and go to S_FETCH.
  - Branch_i with comp_i=0 resolves to pc+4.
- S_TRAP:
  - trap_o=1, imem_req_o=0, instr_valid_o=0; stall_i is ignored.
  - On trap_clear_i: pc<=TRAP_VEC, trap_o cleared next cycle, go to S_FETCH.
- Output timing: all outputs are registered or decoded from state except link_o, which is combinational from pc.
- Unused inputs: comp_i is ignored unless branch_i=1 in S_EXEC.

Decomposition:
- risc_v_32_i_pkg gains:
  - pc_state_e: S_RESET, S_FETCH, S_EXEC, S_TRAP.
  - trap_cause_e: TRAP_NONE, TRAP_MISALIGN, TRAP_FETCH_TO.
  - next_pc_sel_e: NPC_SEQ, NPC_BRANCH, NPC_JAL, NPC_JALR.
- One combinational sub-module, next_pc_calc, does the priority select, adders and alignment check. The FSM, counter and registers stay in pc_sequencer.

Test Plan:
- Reset then ack every fetch in 1 cycle, no control bits -> imem_addr_o 0x0, 0x4, 0x8; instr_valid_o pulses one cycle per instruction.
- At pc=0x10: branch_i=1, comp_i=1, imm=0xFFFFFFF8 -> next fetch at 0x08. Repeat with comp_i=0 -> 0x14.
- At pc=0x20: jalr_i=1 and jal_i=1, rs1=0x1001, imm=0x3 -> JALR wins; target 0x1004 fetched; link_o=0x24.
- At pc=0x40: jal_i=1, imm=0x6 -> trap_o=1, cause 1, trap_addr 0x46, pc_o stays 0x40. trap_clear_i -> fetch at 0x100.
- Withhold ack with TIMEOUT=16 -> trap cause 2 after 16 S_FETCH cycles, trap_addr=pc. A second run acks in cycle 16 -> no trap.
- Assert stall_i for 3 cycles in S_EXEC -> pc and instr_o held, no imem_req_o. Assert rst_i mid-fetch -> pc_o=0x0, all outputs 0 immediately.
